// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's two handshakes.
//   Memory side : mem_req_valid/ready/addr out, mem_rsp_valid/data back.
//   Decode side : inst_valid/data/pc out, inst_ready back.
// Modports: master = fetch unit, slave = memory + decode environment.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [INST_WIDTH-1:0] mem_rsp_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a prefetch FIFO and PC redirect.
//   clk, reset_n       : clock, asynchronous active-low reset
//   fetch_enable       : permit new memory requests
//   redirect_valid/pc  : load new fetch address, flush prefetched state
//   busy               : request outstanding or FIFO non-empty
//   bus (master)       : memory request/response and decode valid/ready
// Optional: define FETCH_UNIT_PERF_CNT_EN to add perf_fetched / perf_stall.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy,
`ifdef FETCH_UNIT_PERF_CNT_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall,
`endif
  fetch_unit_if.master          bus
);
  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_valid_q, req_valid_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic                  push, pop, accept, resume;

  always_comb begin
    pop    = (count_q != '0) && bus.inst_ready;
    accept = req_valid_q && bus.mem_req_ready;
    push   = (state_q == WAIT) && bus.mem_rsp_valid && !redirect_valid;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // Credit for the next request is judged on post-push/pop occupancy.
    resume = fetch_enable && (count_d < DEPTH_C);

    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    req_valid_d = req_valid_q;

    if (redirect_valid)
      fetch_pc_d = redirect_pc;
    else if (accept && state_q == REQ)
      fetch_pc_d = req_addr_q + ADDR_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && fetch_enable && count_q < DEPTH_C) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        // A redirected request that is not yet accepted stays presented
        // (valid/addr stable); DRAIN retires it and discards its response.
        if (accept)         req_valid_d = 1'b0;
        if (redirect_valid) state_d     = DRAIN;
        else if (accept)    state_d     = WAIT;
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (resume) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (req_valid_q) begin
          if (bus.mem_req_ready) req_valid_d = 1'b0;
        end else if (bus.mem_rsp_valid) begin
          if (resume) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_addr_q;
      data_mem_q[wr_ptr_q] <= bus.mem_rsp_data;
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.inst_valid    = (count_q != '0);
  assign bus.inst_data     = data_mem_q[rd_ptr_q];
  assign bus.inst_pc       = pc_mem_q[rd_ptr_q];
  assign busy              = busy_q;

`ifdef FETCH_UNIT_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_stall_d   = perf_stall_q + 32'(bus.inst_ready && count_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (RESET_PC=0x10, depth 4).
// The memory model answers each accepted request one cycle later with
// data = addr + 0x100, unless rsp_hold parks the response.
module tb_fetch_unit;
  logic       clk;
  logic       reset_n;
  logic       fetch_enable;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       busy;
`ifdef FETCH_UNIT_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit_if #(.ADDR_WIDTH(8), .INST_WIDTH(32)) bus ();

  fetch_unit #(
    .ADDR_WIDTH(8),
    .INST_WIDTH(32),
    .FIFO_DEPTH(4),
    .RESET_PC  (8'h10)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_enable  (fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy),
`ifdef FETCH_UNIT_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       rsp_hold;
  logic [7:0] req_log [$];
  logic [7:0] pend    [$];
  logic [7:0] dlv_pc  [$];
  logic [31:0] dlv_data [$];
  int         dlv_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes before the edge, drive memory response after.
  task automatic tick();
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      req_log.push_back(bus.mem_req_addr);
      pend.push_back(bus.mem_req_addr);
    end
    if (bus.inst_valid && bus.inst_ready) begin
      dlv_pc.push_back(bus.inst_pc);
      dlv_data.push_back(bus.inst_data);
      dlv_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.mem_rsp_valid = 1'b0;
    if (!rsp_hold && pend.size() > 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h100 + 32'(pend.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_data.delete();
    dlv_cyc.delete();
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},  32'(bus.mem_req_valid), 32'h0);
    check({tag, "_req_addr"},   32'(bus.mem_req_addr),  32'h10);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid),    32'h0);
    check({tag, "_inst_data"},  bus.inst_data,          32'h0);
    check({tag, "_inst_pc"},    32'(bus.inst_pc),       32'h0);
    check({tag, "_busy"},       32'(busy),              32'h0);
  endtask

  initial begin
    int n;
    reset_n           = 1'b1;
    fetch_enable      = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    rsp_hold          = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.inst_ready    = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check_reset_outputs("reset");
`ifdef FETCH_UNIT_PERF_CNT_EN
    check("perf_fetched_reset", perf_fetched, 32'h0);
    check("perf_stall_reset",   perf_stall,   32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Sequential fetch from RESET_PC with minimum latency.
    fetch_enable   = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    check("lat_req_valid", 32'(bus.mem_req_valid), 32'h1);
    check("lat_req_addr",  32'(bus.mem_req_addr),  32'h10);
    check("lat_no_inst",   32'(bus.inst_valid),    32'h0);
    tick();
    check("lat_wait", 32'(bus.mem_req_valid), 32'h0);
    tick();
    check("lat_inst_valid", 32'(bus.inst_valid), 32'h1);
    check("lat_inst_pc",    32'(bus.inst_pc),    32'h10);
    check("lat_inst_data",  bus.inst_data,       32'h110);
    check("lat_next_addr",  32'(bus.mem_req_addr), 32'h11);
    n = 0;
    while (dlv_pc.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    check("seq_count", 32'(dlv_pc.size() >= 3), 32'h1);
    check("seq_pc0",   32'(dlv_pc[0]), 32'h10);
    check("seq_data0", dlv_data[0],    32'h110);
    check("seq_pc1",   32'(dlv_pc[1]), 32'h11);
    check("seq_data1", dlv_data[1],    32'h111);
    check("seq_pc2",   32'(dlv_pc[2]), 32'h12);
    check("seq_data2", dlv_data[2],    32'h112);
    check("thru_gap1", 32'(dlv_cyc[1] - dlv_cyc[0]), 32'h2);
    check("thru_gap2", 32'(dlv_cyc[2] - dlv_cyc[1]), 32'h2);
    fetch_enable = 1'b0;
    wait_idle("seq_idle");

    // Credit limit: decode stalled, exactly FIFO_DEPTH requests.
    clear_logs();
    bus.inst_ready = 1'b0;
    fetch_enable   = 1'b1;
    redirect_to(8'h20);
    check("redir_idle_stays", 32'(bus.mem_req_valid), 32'h0);
    ticks(20);
    check("credit_reqs",      32'(req_log.size()),    32'h4);
    check("credit_last_addr", 32'(req_log[3]),        32'h23);
    check("credit_no_req",    32'(bus.mem_req_valid), 32'h0);
    check("credit_head_pc",   32'(bus.inst_pc),       32'h20);
    check("credit_head_data", bus.inst_data,          32'h120);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("credit_pop_head", 32'(bus.inst_pc), 32'h21);
    ticks(8);
    check("credit_reqs_after_pop", 32'(req_log.size()), 32'h5);
    check("credit_head_plus4",     32'(req_log[4]),     32'h24);

    // Redirect in WAIT with 3 entries buffered.
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    rsp_hold       = 1'b1;
    ticks(2);
    check("wait_head_pc", 32'(bus.inst_pc),       32'h22);
    check("wait_no_req",  32'(bus.mem_req_valid), 32'h0);
    check("wait_busy",    32'(busy),              32'h1);
    redirect_to(8'h40);
    check("flush_empty", 32'(bus.inst_valid), 32'h0);
    check("drain_busy",  32'(busy),           32'h1);
    clear_logs();
    ticks(3);
    check("drain_no_req",  32'(bus.mem_req_valid), 32'h0);
    check("drain_no_inst", 32'(bus.inst_valid),    32'h0);
    rsp_hold       = 1'b0;
    bus.inst_ready = 1'b1;
    n = 0;
    while (dlv_pc.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    check("redir_count", 32'(dlv_pc.size() >= 1), 32'h1);
    check("redir_pc",    32'(dlv_pc[0]), 32'h40);
    check("redir_data",  dlv_data[0],    32'h140);
    fetch_enable = 1'b0;
    wait_idle("redir_idle");

    // Memory back-pressure: request held stable, accepted once.
    clear_logs();
    redirect_to(8'h80);
    bus.mem_req_ready = 1'b0;
    fetch_enable      = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.mem_req_valid), 32'h1);
      check("stall_addr",  32'(bus.mem_req_addr),  32'h80);
      tick();
    end
    check("stall_count", 32'(req_log.size()), 32'h0);
    bus.mem_req_ready = 1'b1;
    fetch_enable      = 1'b0;
    tick();
    check("stall_accepted", 32'(bus.mem_req_valid), 32'h0);
    ticks(4);
    check("stall_single", 32'(req_log.size()), 32'h1);
    check("stall_dlv",    32'(dlv_pc.size()),  32'h1);
    check("stall_pc",     32'(dlv_pc[0]),      32'h80);
    check("stall_data",   dlv_data[0],         32'h180);
    check("stall_idle",   32'(busy),           32'h0);

    // PC wrap 0xFF -> 0x00.
    clear_logs();
    redirect_to(8'hFE);
    fetch_enable = 1'b1;
    n = 0;
    while (req_log.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    check("wrap_count", 32'(req_log.size() >= 3), 32'h1);
    check("wrap_ff",    32'(req_log[1]), 32'hFF);
    check("wrap_00",    32'(req_log[2]), 32'h00);
    fetch_enable = 1'b0;
    wait_idle("wrap_idle");
    check("wrap_dlv_pc",   32'(dlv_pc[2]), 32'h00);
    check("wrap_dlv_data", dlv_data[2],    32'h100);

    // Asynchronous reset in WAIT with 2 entries; late response ignored.
    clear_logs();
    redirect_to(8'h30);
    bus.inst_ready = 1'b0;
    fetch_enable   = 1'b1;
    ticks(5);
    rsp_hold = 1'b1;
    tick();
    check("pre_rst_valid", 32'(bus.inst_valid),    32'h1);
    check("pre_rst_pc",    32'(bus.inst_pc),       32'h30);
    check("pre_rst_wait",  32'(bus.mem_req_valid), 32'h0);
    check("pre_rst_reqs",  32'(req_log.size()),    32'h3);
    reset_n      = 1'b0;
    fetch_enable = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ticks(2);
    reset_n  = 1'b1;
    rsp_hold = 1'b0;
    ticks(3);
    check("late_rsp_no_inst", 32'(bus.inst_valid),    32'h0);
    check("late_rsp_idle",    32'(busy),              32'h0);
    check("late_rsp_no_req",  32'(bus.mem_req_valid), 32'h0);
    check("late_rsp_addr",    32'(bus.mem_req_addr),  32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
